// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter : shares the single-port data memory between the pipeline MEM
//                stage and a debug/loader host, sequencing IDLE->ACCESS->RESP.
// Revision     : 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_req,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic [DATA_W-1:0] pipe_rdata,
  output logic              pipe_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [2:0] LAT_LAST   = 3'(MEM_LATENCY - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic       OWN_PIPE   = 1'b0;
  localparam logic       OWN_DBG    = 1'b1;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic [2:0]        lat_q, lat_d;
  logic [3:0]        starve_q, starve_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] pipe_rdata_q, pipe_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              grant_pipe, grant_dbg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_PIPE;
      lat_q        <= '0;
      starve_q     <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      pipe_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lat_q        <= lat_d;
      starve_q     <= starve_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      pipe_rdata_q <= pipe_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lat_d        = lat_q;
    starve_d     = starve_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    pipe_rdata_d = pipe_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    grant_pipe   = 1'b0;
    grant_dbg    = 1'b0;

    case (state_q)
      IDLE: begin
        // Pipeline has priority until the host has been passed over STARVE_LIMIT times.
        grant_dbg  = dbg_req & (~pipe_req | (starve_q == STARVE_MAX));
        grant_pipe = pipe_req & ~grant_dbg;
        if (grant_dbg) begin
          owner_d  = OWN_DBG;
          we_d     = dbg_we;
          addr_d   = dbg_addr;
          wdata_d  = dbg_wdata;
          starve_d = '0;
        end else if (grant_pipe) begin
          owner_d = OWN_PIPE;
          we_d    = pipe_we;
          addr_d  = pipe_addr;
          wdata_d = pipe_wdata;
          if (dbg_req && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
          end else if (!dbg_req) begin
            starve_d = '0;
          end
        end else if (!dbg_req) begin
          starve_d = '0;
        end
        if (grant_pipe || grant_dbg) begin
          state_d = ACCESS;
          lat_d   = '0;
        end
      end
      ACCESS: begin
        if (lat_q == LAT_LAST) begin
          state_d = RESP;
          lat_d   = '0;
          if (!we_q) begin
            if (owner_q == OWN_DBG) begin
              dbg_rdata_d = mem_rdata;
            end else begin
              pipe_rdata_d = mem_rdata;
            end
          end
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_en     = (state_q == ACCESS);
  assign mem_we     = mem_en & we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign pipe_rdata = pipe_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign dbg_ack    = (state_q == RESP) & (owner_q == OWN_DBG);
  // Released only in the pipeline's own RESP cycle; a flushed request never stalls.
  assign pipe_stall = pipe_req & ~((state_q == RESP) & (owner_q == OWN_PIPE));

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// Scoreboard bench for dmem_arbiter: expected grants and completions are queued
// by the stimulus and popped by a negedge monitor; the bench also models the memory.
module tb_dmem_arbiter;

  localparam int ADDR_W       = 8;
  localparam int DATA_W       = 8;
  localparam int MEM_LATENCY  = 2;
  localparam int STARVE_LIMIT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              pipe_req, pipe_we;
  logic [ADDR_W-1:0] pipe_addr;
  logic [DATA_W-1:0] pipe_wdata, pipe_rdata;
  logic              pipe_stall;
  logic              dbg_req, dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
  logic              dbg_ack;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LATENCY(MEM_LATENCY), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .pipe_req(pipe_req), .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
    .pipe_rdata(pipe_rdata), .pipe_stall(pipe_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Fixed-latency memory: read data is only valid in the last ACCESS cycle.
  logic [7:0] mem [0:255];
  int acc_cyc = 0;
  assign mem_rdata = (mem_en && acc_cyc == MEM_LATENCY - 1) ? mem[mem_addr] : 8'hEE;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] = mem_wdata;
      acc_cyc <= acc_cyc + 1;
    end else begin
      acc_cyc <= 0;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } grant_t;

  grant_t     grant_q[$];
  logic [7:0] pipe_q[$];
  logic [7:0] dbg_q[$];

  // Monitor
  logic   prev_en  = 1'b0;
  logic   prev_ack = 1'b0;
  int     burst_len = 0;
  grant_t cur = '{1'b0, 8'h00, 8'h00};
  logic [7:0] exp_byte;

  always @(negedge clk) begin
    if (!reset) begin
      burst_len = 0;
      prev_en   = 1'b0;
      prev_ack  = 1'b0;
    end else begin
      if (mem_en) begin
        if (!prev_en) begin
          if (grant_q.size() == 0) begin
            check("unexpected_grant", 1, 0);
          end else begin
            cur = grant_q.pop_front();
            check("grant_we", int'(mem_we), int'(cur.we));
            check("grant_addr", int'(mem_addr), int'(cur.addr));
            if (cur.we) check("grant_wdata", int'(mem_wdata), int'(cur.wdata));
          end
          burst_len = 1;
        end else begin
          burst_len++;
          check("access_addr_stable", int'(mem_addr), int'(cur.addr));
          check("access_we_stable", int'(mem_we), int'(cur.we));
        end
      end else if (prev_en) begin
        check("access_len", burst_len, MEM_LATENCY);
        check("resp_mem_we", int'(mem_we), 0);
      end
      if (dbg_ack) begin
        check("dbg_ack_pulse", int'(prev_ack), 0);
        if (dbg_q.size() == 0) begin
          check("unexpected_dbg_ack", 1, 0);
        end else begin
          exp_byte = dbg_q.pop_front();
          check("dbg_rdata", int'(dbg_rdata), int'(exp_byte));
        end
      end
      if (pipe_req && !pipe_stall) begin
        if (pipe_q.size() == 0) begin
          check("unexpected_pipe_done", 1, 0);
        end else begin
          exp_byte = pipe_q.pop_front();
          check("pipe_rdata", int'(pipe_rdata), int'(exp_byte));
        end
      end
      prev_en  = mem_en;
      prev_ack = dbg_ack;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pipe_done(output int stall_cycles);
    stall_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!pipe_stall) return;
      stall_cycles++;
    end
    check("pipe_done_timeout", 1, 0);
  endtask

  task automatic wait_dbg_ack();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dbg_ack) return;
    end
    check("dbg_ack_timeout", 1, 0);
  endtask

  task automatic dbg_access(input bit we, input logic [7:0] addr, input logic [7:0] wdata);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
    wait_dbg_ack();
    tick();
    dbg_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int stalls;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
    mem[8'h10] = 8'h5A;
    mem[8'h11] = 8'hC3;
    mem[8'h12] = 8'h99;
    mem[8'h13] = 8'h6E;
    mem[8'h20] = 8'h00;
    mem[8'h07] = 8'h11;

    reset = 1'b0;
    pipe_req = 1'b0; pipe_we = 1'b0; pipe_addr = '0; pipe_wdata = '0;
    dbg_req  = 1'b0; dbg_we  = 1'b0; dbg_addr  = '0; dbg_wdata  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_en", int'(mem_en), 0);
    check("rst_mem_we", int'(mem_we), 0);
    check("rst_dbg_ack", int'(dbg_ack), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_mem_wdata", int'(mem_wdata), 0);
    check("rst_pipe_rdata", int'(pipe_rdata), 0);
    check("rst_dbg_rdata", int'(dbg_rdata), 0);
    check("rst_pipe_stall", int'(pipe_stall), 0);
    reset = 1'b1;
    tick();

    // Reset lands in the second ACCESS cycle of a pipeline read
    pipe_req = 1'b1; pipe_we = 1'b0; pipe_addr = 8'h12;
    grant_q.push_back('{1'b0, 8'h12, 8'h00});
    tick();
    tick();
    check("t1_in_access", int'(mem_en), 1);
    reset = 1'b0;
    #1;
    check("t1_abort_mem_en", int'(mem_en), 0);
    check("t1_abort_stall", int'(pipe_stall), 1);
    check("t1_abort_ack", int'(dbg_ack), 0);
    tick();
    tick();
    reset = 1'b1;
    grant_q.push_back('{1'b0, 8'h12, 8'h00});
    pipe_q.push_back(8'h99);
    wait_pipe_done(stalls);
    check("t1_regrant_stalls", stalls, MEM_LATENCY + 1);
    tick();
    pipe_req = 1'b0;
    tick();

    // Plain pipeline read
    pipe_req = 1'b1; pipe_we = 1'b0; pipe_addr = 8'h10;
    grant_q.push_back('{1'b0, 8'h10, 8'h00});
    pipe_q.push_back(8'h5A);
    wait_pipe_done(stalls);
    check("t2_stalls", stalls, MEM_LATENCY + 1);
    tick();
    pipe_req = 1'b0;
    check("t2_pipe_rdata_hold", int'(pipe_rdata), 8'h5A);
    tick();

    // Debug write then read back
    grant_q.push_back('{1'b1, 8'h20, 8'h33});
    dbg_q.push_back(8'h00);
    dbg_access(1'b1, 8'h20, 8'h33);
    tick();
    grant_q.push_back('{1'b0, 8'h20, 8'h00});
    dbg_q.push_back(8'h33);
    dbg_access(1'b0, 8'h20, 8'h00);
    check("t3_pipe_rdata_unchanged", int'(pipe_rdata), 8'h5A);
    tick();

    // Pipeline write abandoned by the requester after the grant
    pipe_req = 1'b1; pipe_we = 1'b1; pipe_addr = 8'h07; pipe_wdata = 8'hA5;
    grant_q.push_back('{1'b1, 8'h07, 8'hA5});
    tick();
    pipe_req = 1'b0; pipe_we = 1'b0; pipe_addr = 8'hFF; pipe_wdata = 8'h00;
    #1;
    check("t5_stall_drop", int'(pipe_stall), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_stall_low", int'(pipe_stall), 0);
    end
    tick();
    grant_q.push_back('{1'b0, 8'h07, 8'h00});
    dbg_q.push_back(8'hA5);
    dbg_access(1'b0, 8'h07, 8'h00);
    check("t5_pipe_rdata_unchanged", int'(pipe_rdata), 8'h5A);
    tick();

    // Both requesters held: P,P,P,P,D then P
    pipe_req = 1'b1; pipe_we = 1'b0; pipe_addr = 8'h10;
    for (int i = 0; i < 4; i++) begin
      grant_q.push_back('{1'b0, 8'h10, 8'h00});
      pipe_q.push_back(8'h5A);
    end
    grant_q.push_back('{1'b0, 8'h11, 8'h00});
    grant_q.push_back('{1'b0, 8'h10, 8'h00});
    pipe_q.push_back(8'h5A);
    dbg_q.push_back(8'hC3);
    dbg_access(1'b0, 8'h11, 8'h00);
    wait_pipe_done(stalls);
    check("t4_resume_stalls", stalls, MEM_LATENCY + 1);
    tick();
    pipe_req = 1'b0;
    tick();

    // Simultaneous fresh requests: pipeline first, then debug
    pipe_req = 1'b1; pipe_we = 1'b0; pipe_addr = 8'h12;
    dbg_req  = 1'b1; dbg_we  = 1'b0; dbg_addr  = 8'h13;
    grant_q.push_back('{1'b0, 8'h12, 8'h00});
    grant_q.push_back('{1'b0, 8'h13, 8'h00});
    pipe_q.push_back(8'h99);
    dbg_q.push_back(8'h6E);
    wait_pipe_done(stalls);
    check("t6_pipe_first_stalls", stalls, MEM_LATENCY + 1);
    tick();
    pipe_req = 1'b0;
    wait_dbg_ack();
    tick();
    dbg_req = 1'b0;
    repeat (4) tick();

    check("grant_q_drained", grant_q.size(), 0);
    check("pipe_q_drained", pipe_q.size(), 0);
    check("dbg_q_drained", dbg_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
